// File: rtl/threshold_tagger_if.sv
// Byte-stream input and tagged-package output bundle for threshold_tagger.
// The master side (UART receiver and cutter) drives the bytes; the slave side (the tagger) drives the tagged-package outputs.
interface threshold_tagger_if #(
    parameter int WINDOW_WIDTH = 256
);
    logic [7:0]            byte_i;
    logic                  byte_valid;
    logic [WINDOW_WIDTH:0] data_o;
    logic                  data_wen;
    logic [15:0]           pkt_cnt;
    logic [15:0]           drop_cnt;

    modport master (
        output byte_i, byte_valid,
        input  data_o, data_wen, pkt_cnt, drop_cnt
    );

    modport slave (
        input  byte_i, byte_valid,
        output data_o, data_wen, pkt_cnt, drop_cnt
    );
endinterface

// File: rtl/threshold_tagger.sv
// Assembles header-framed sensor packages and tags each one with an acceleration-energy threshold flag.
//  state   | meaning
//  HUNT    | waiting for a HEADER byte to start a package
//  COLLECT | storing bytes 1..PKG_BYTES-1; aborts to HUNT after TIMEOUT idle cycles
module threshold_tagger #(
    parameter int          WINDOW_WIDTH = 256,
    parameter logic [7:0]  HEADER       = 8'h55,
    parameter int          AZ_BYTE      = 18,
    parameter int          AY_BYTE      = 20,
    parameter int          AX_BYTE      = 22,
    parameter logic [31:0] THRESHOLD    = 32'h0010_0000,
    parameter int          TIMEOUT      = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    threshold_tagger_if.slave bus
);
    localparam int PKG_BYTES = WINDOW_WIDTH / 8;
    localparam int IDX_W     = $clog2(PKG_BYTES);
    localparam int IDLE_W    = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PKG_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        byte_idx_q;
    logic [IDLE_W-1:0]       idle_q;
    logic [15:0]             drop_q;
    logic [15:0]             pkt_q;
    logic [WINDOW_WIDTH-1:0] pkg_q;
    logic                    pipe_v_q, s1_v_q, s2_v_q, wen_q;
    logic [WINDOW_WIDTH-1:0] pkg0_q, pkg1_q, pkg2_q;
    logic [31:0]             sq_x_q, sq_y_q, sq_z_q;
    logic [33:0]             sum_q;
    logic [WINDOW_WIDTH:0]   data_q;
    logic                    last_byte;
    logic                    store_byte;
    logic [31:0]             sq_x_d, sq_y_d, sq_z_d;
    logic [33:0]             sum_d;

    function automatic logic [31:0] square16(input logic [7:0] hi, input logic [7:0] lo);
        logic signed [15:0] s;
        logic signed [31:0] w;
        s = {hi, lo};
        w = 32'(s);
        return w * w;
    endfunction

    assign last_byte  = (state_q == COLLECT) && bus.byte_valid && (byte_idx_q == LAST_IDX);
    assign store_byte = bus.byte_valid && ((state_q == COLLECT) || (bus.byte_i == HEADER));

    always_comb begin
        sq_x_d = square16(pkg0_q[8*AX_BYTE +: 8], pkg0_q[8*(AX_BYTE+1) +: 8]);
        sq_y_d = square16(pkg0_q[8*AY_BYTE +: 8], pkg0_q[8*(AY_BYTE+1) +: 8]);
        sq_z_d = square16(pkg0_q[8*AZ_BYTE +: 8], pkg0_q[8*(AZ_BYTE+1) +: 8]);
        sum_d  = 34'(sq_x_q) + 34'(sq_y_q) + 34'(sq_z_q);
    end

    // Payload registers carry no reset; only the valid bits decide what reaches the output.
    always_ff @(posedge clk) begin
        if (store_byte)
            pkg_q[{byte_idx_q, 3'b000} +: 8] <= bus.byte_i;
        if (last_byte)
            pkg0_q <= {bus.byte_i, pkg_q[WINDOW_WIDTH-9:0]};
        if (pipe_v_q) begin
            pkg1_q <= pkg0_q;
            sq_x_q <= sq_x_d;
            sq_y_q <= sq_y_d;
            sq_z_q <= sq_z_d;
        end
        if (s1_v_q) begin
            pkg2_q <= pkg1_q;
            sum_q  <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            byte_idx_q <= '0;
            idle_q     <= '0;
            drop_q     <= '0;
            pkt_q      <= '0;
            pipe_v_q   <= 1'b0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            wen_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            pipe_v_q <= last_byte;
            s1_v_q   <= pipe_v_q;
            s2_v_q   <= s1_v_q;
            wen_q    <= s2_v_q;
            if (s2_v_q) begin
                data_q <= {pkg2_q, (sum_q >= {2'b00, THRESHOLD})};
                pkt_q  <= pkt_q + 16'd1;
            end
            case (state_q)
                HUNT: begin
                    idle_q <= '0;
                    if (bus.byte_valid && (bus.byte_i == HEADER)) begin
                        byte_idx_q <= IDX_W'(1);
                        state_q    <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A byte arriving on the timeout cycle is still accepted.
                    if (bus.byte_valid) begin
                        idle_q <= '0;
                        if (byte_idx_q == LAST_IDX) begin
                            byte_idx_q <= '0;
                            state_q    <= HUNT;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                        end
                    end else if (idle_q == IDLE_LAST) begin
                        idle_q     <= '0;
                        byte_idx_q <= '0;
                        state_q    <= HUNT;
                        if (drop_q != 16'hFFFF)
                            drop_q <= drop_q + 16'd1;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign bus.data_o   = data_q;
    assign bus.data_wen = wen_q;
    assign bus.pkt_cnt  = pkt_q;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_threshold_tagger.sv
// Scoreboard bench for threshold_tagger: directed packages push expected words, a negedge monitor checks every strobe.
module tb_threshold_tagger;
    localparam int TIMEOUT = 1000;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_pkt = 0;

    typedef struct {
        logic [256:0] data;
        int           cyc;
        logic [15:0]  pkt;
    } exp_t;
    exp_t sb[$];

    threshold_tagger_if #(.WINDOW_WIDTH(256)) bus ();

    threshold_tagger dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.data_wen === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wen: strobe at cycle %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_o", bus.data_o, e.data);
                chk("wen_cycle", 257'(cyc), 257'(e.cyc));
                chk("pkt_cnt_at_wen", 257'(bus.pkt_cnt), 257'(e.pkt));
            end
        end
    end

    function automatic logic [255:0] make_pkg(input logic [15:0] ax, input logic [15:0] ay,
                                              input logic [15:0] az, input logic [7:0] seed);
        logic [255:0] p;
        for (int k = 0; k < 32; k++) p[8*k +: 8] = 8'(k * 13) ^ seed;
        p[7:0]        = 8'h55;
        p[47:40]      = 8'h55;
        p[8*18 +: 8]  = az[15:8];
        p[8*19 +: 8]  = az[7:0];
        p[8*20 +: 8]  = ay[15:8];
        p[8*21 +: 8]  = ay[7:0];
        p[8*22 +: 8]  = ax[15:8];
        p[8*23 +: 8]  = ax[7:0];
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bus.byte_i     = b;
        bus.byte_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_pkg(input logic [255:0] p, input logic flag, input bit push);
        exp_t e;
        for (int k = 0; k < 32; k++) send_byte(p[8*k +: 8]);
        if (push) begin
            exp_pkt++;
            e.data = {p, flag};
            e.cyc  = cyc + 3;
            e.pkt  = 16'(exp_pkt);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d strobes outstanding, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [255:0] p;
        bus.byte_i     = 8'h00;
        bus.byte_valid = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_data_o", bus.data_o, 257'd0);
        chk("rst_data_wen", 257'(bus.data_wen), 257'd0);
        chk("rst_pkt_cnt", 257'(bus.pkt_cnt), 257'd0);
        chk("rst_drop_cnt", 257'(bus.drop_cnt), 257'd0);

        // nominal: energy exactly THRESHOLD
        p = make_pkg(16'h0400, 16'h0000, 16'h0000, 8'h11);
        send_pkg(p, 1'b1, 1);
        drain("nominal");
        chk("nominal_pkt_cnt", 257'(bus.pkt_cnt), 257'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_data_o", bus.data_o, {p, 1'b1});

        // threshold boundaries
        send_pkg(make_pkg(16'h03FF, 16'h0000, 16'h0000, 8'h22), 1'b0, 1);
        send_pkg(make_pkg(16'hFC00, 16'h0000, 16'h0000, 8'h33), 1'b1, 1);
        send_pkg(make_pkg(16'h8000, 16'h8000, 16'h8000, 8'h44), 1'b1, 1);
        drain("boundary");
        chk("boundary_pkt_cnt", 257'(bus.pkt_cnt), 257'd4);

        // header hunt
        send_byte(8'h00);
        send_byte(8'hAA);
        send_pkg(make_pkg(16'h0000, 16'h0400, 16'h0000, 8'h5A), 1'b1, 1);
        drain("hunt");
        chk("hunt_drop_cnt", 257'(bus.drop_cnt), 257'd0);

        // timeout of a partial package
        p = make_pkg(16'h0400, 16'h0000, 16'h0000, 8'h66);
        for (int k = 0; k < 11; k++) send_byte(p[8*k +: 8]);
        repeat (TIMEOUT) @(posedge clk);
        #1;
        chk("timeout_drop_cnt", 257'(bus.drop_cnt), 257'd1);
        send_pkg(make_pkg(16'h0000, 16'h0000, 16'h03FF, 8'h77), 1'b0, 1);
        drain("timeout");
        chk("timeout_pkt_cnt", 257'(bus.pkt_cnt), 257'd6);
        chk("timeout_drop_after", 257'(bus.drop_cnt), 257'd1);

        // back-to-back, flags 1,0,1,0,1
        send_pkg(make_pkg(16'h0400, 16'h0000, 16'h0000, 8'h81), 1'b1, 1);
        send_pkg(make_pkg(16'h0000, 16'h0200, 16'h0200, 8'h82), 1'b0, 1);
        send_pkg(make_pkg(16'h0000, 16'h0000, 16'h0400, 8'h83), 1'b1, 1);
        send_pkg(make_pkg(16'h0300, 16'h0200, 16'h0000, 8'h84), 1'b0, 1);
        send_pkg(make_pkg(16'hFC00, 16'h0000, 16'h0000, 8'h85), 1'b1, 1);
        drain("b2b");
        chk("b2b_pkt_cnt", 257'(bus.pkt_cnt), 257'd11);

        // reset one cycle after the last byte of an in-flight package
        send_pkg(make_pkg(16'h8000, 16'h0000, 16'h0000, 8'h99), 1'b1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_pkt = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_pkt_cnt", 257'(bus.pkt_cnt), 257'd0);
        chk("midrst_drop_cnt", 257'(bus.drop_cnt), 257'd0);
        chk("midrst_data_o", bus.data_o, 257'd0);

        // the tagger still works after the mid-flight reset
        send_pkg(make_pkg(16'h0000, 16'h0000, 16'h0400, 8'hA5), 1'b1, 1);
        drain("post_rst");
        chk("post_rst_pkt_cnt", 257'(bus.pkt_cnt), 257'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
